stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Control FSM for the stopwatch. Decodes the debounced START/STOP and LAP/RESET buttons and sequences
//   the BCD time-counter chain. Drives a prescaled count-enable tick, a synchronous clear pulse and a
//   display-hold flag (lap freeze). Sits between the button debouncers and the counter/display datapath.
// PARAMETERS
//   CLK_DIV  500000  CLK cycles per tick (50 MHz -> 100 Hz centiseconds); legal range >= 2
//   PRESC_W  19      prescaler width; must satisfy 2**PRESC_W >= CLK_DIV
// PORTS
//   CLK             in   1        system clock, rising edge
//   rst_n           in   1        asynchronous, active-low reset
//   btn_start_stop  in   1        debounced level, synchronous to CLK, high = pressed
//   btn_lap_reset   in   1        debounced level, synchronous to CLK, high = pressed
//   tick            out  1        one-cycle count-enable pulse to the time counter
//   count_clr       out  1        one-cycle synchronous clear pulse to the time counter
//   disp_hold       out  1        high = display keeps its latched (lap) value
//   running         out  1        high in RUN or LAP
//   state           out  2        IDLE=00, RUN=01, PAUSE=10, LAP=11
// BEHAVIOUR
// - Reset (rst_n low, no clock required): state=IDLE, prescaler=0, tick=0, count_clr=0, disp_hold=0,
//   running=0, both button-history regs=1, so a button held through reset does not fire.
// - Press = level & ~prev, evaluated per edge; exactly one press per rising level, however long it is held.
// - Both presses in one cycle: start_stop wins, lap_reset is dropped.
// - Transitions (taken on the edge that samples the press):
//     IDLE : ss -> RUN;  lr -> IDLE + count_clr
//     RUN  : ss -> PAUSE; lr -> LAP
//     LAP  : ss -> PAUSE (hold released); lr -> RUN (hold released)
//     PAUSE: ss -> RUN;  lr -> IDLE + count_clr, prescaler <= 0
// - All outputs are registered. State-derived outputs (running, disp_hold, state) change on the
//   transition edge. count_clr is high for exactly the one cycle after that edge.
// - disp_hold = (state==LAP). Ticks keep flowing in LAP; only the display is frozen.
// - Prescaler advances on every edge whose pre-edge state is RUN or LAP:
//     if presc==CLK_DIV-1 then presc<=0, tick<=1; else presc<=presc+1, tick<=0.
//   On all other edges tick<=0 and presc holds its value.
// - Pause preserves the partial period: after resume, the first tick comes after CLK_DIV-P edges,
//   where P is the frozen prescaler value.
// - From IDLE, the first tick is registered high on the CLK_DIV-th edge after the RUN-entry edge.
//   Ticks then repeat every CLK_DIV cycles, each 1 cycle wide.
// - tick and count_clr are never high in the same cycle.
// - rst_n asserted mid-operation aborts everything immediately. After release, the block waits in IDLE
//   for a fresh press.
// TESTING (bench uses CLK_DIV=4, PRESC_W=2)
//  1. Run, then drop rst_n between edges -> all outputs 0 and state=00 before the next edge;
//     released with ss still high -> stays IDLE.
//  2. IDLE, pulse ss -> running=1, state=01 on that edge. tick high on edges 4, 8, 12 after it;
//     exactly 3 ticks in 12 cycles.
//  3. Pause with presc frozen at 1, hold 10 cycles -> no tick, running=0. Resume -> tick exactly
//     3 edges after the resume edge.
//  4. RUN, lr press -> state=11, disp_hold=1, ticks continue every 4 cycles. lr again -> state=01,
//     disp_hold=0. ss from LAP -> state=10, disp_hold=0.
//  5. PAUSE, lr press -> state=00, count_clr high one cycle, presc=0. lr in IDLE -> count_clr again.
//     lr in RUN -> no count_clr.
//  6. RUN with ss and lr rising in the same cycle -> PAUSE only. ss held high 20 cycles -> single
//     transition, no toggling.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: decodes debounced start/stop and lap/reset buttons,
// generates the prescaled count-enable tick, the counter clear pulse and the
// display-hold (lap freeze) flag.
module stopwatch_ctrl #(
  parameter int CLK_DIV = 500000,
  parameter int PRESC_W = 19
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  output logic       tick,
  output logic       count_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);

  state_t             st;
  logic [PRESC_W-1:0] presc;
  logic               ss_prev;
  logic               lr_prev;
  logic               ss_press;
  logic               lr_press;

  // Rising-level press detection; start/stop wins when both rise together.
  always_comb begin
    ss_press = btn_start_stop & ~ss_prev;
    lr_press = btn_lap_reset & ~lr_prev & ~ss_press;
  end

  assign state = st;

  // State machine, prescaler and all registered outputs.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      presc     <= '0;
      tick      <= 1'b0;
      count_clr <= 1'b0;
      disp_hold <= 1'b0;
      running   <= 1'b0;
      // Histories start high so a button held through reset does not fire.
      ss_prev   <= 1'b1;
      lr_prev   <= 1'b1;
    end else begin
      ss_prev   <= btn_start_stop;
      lr_prev   <= btn_lap_reset;
      count_clr <= 1'b0;
      tick      <= 1'b0;

      // Prescaler advances based on the state before this edge.
      if (st == RUN || st == LAP) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          tick  <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      unique case (st)
        IDLE: begin
          if (ss_press) begin
            st      <= RUN;
            running <= 1'b1;
          end else if (lr_press) begin
            count_clr <= 1'b1;
          end
        end
        RUN: begin
          if (ss_press) begin
            st      <= PAUSE;
            running <= 1'b0;
          end else if (lr_press) begin
            st        <= LAP;
            disp_hold <= 1'b1;
          end
        end
        LAP: begin
          if (ss_press) begin
            st        <= PAUSE;
            running   <= 1'b0;
            disp_hold <= 1'b0;
          end else if (lr_press) begin
            st        <= RUN;
            disp_hold <= 1'b0;
          end
        end
        PAUSE: begin
          if (ss_press) begin
            st      <= RUN;
            running <= 1'b1;
          end else if (lr_press) begin
            st        <= IDLE;
            count_clr <= 1'b1;
            presc     <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with CLK_DIV=4.
module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_lap_reset = 1'b0;
  logic       tick;
  logic       count_clr;
  logic       disp_hold;
  logic       running;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(.CLK_DIV(4), .PRESC_W(2)) dut (
    .CLK            (CLK),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_lap_reset  (btn_lap_reset),
    .tick           (tick),
    .count_clr      (count_clr),
    .disp_hold      (disp_hold),
    .running        (running),
    .state          (state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ss;
    logic       lr;
    logic       tick;
    logic       clr;
    logic       hold;
    logic       run;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic ss, input logic lr, input logic t,
                              input logic c, input logic h, input logic r,
                              input logic [1:0] s);
    vec_t v;
    v.ss = ss; v.lr = lr; v.tick = t; v.clr = c; v.hold = h; v.run = r; v.st = s;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {tick, count_clr, disp_hold, running, state};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {tick,clr,hold,run,state} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic ss, input logic lr);
    btn_start_stop = ss;
    btn_lap_reset  = lr;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Test 2: start, ticks on edges 4, 8, 12
    add(1,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 1,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 1,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 1,0,0,1,2'b01);
    // Test 3: pause with prescaler frozen at 1, hold 10 cycles, resume
    add(1,0, 0,0,0,0,2'b10);
    for (int i = 0; i < 10; i++) add(0,0, 0,0,0,0,2'b10);
    add(1,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,0, 1,0,0,1,2'b01);
    // Test 4: lap freeze, ticks continue, lap release, stop from lap
    add(0,1, 0,0,1,1,2'b11);
    add(0,0, 0,0,1,1,2'b11);
    add(0,0, 0,0,1,1,2'b11);
    add(0,0, 1,0,1,1,2'b11);
    add(0,1, 0,0,0,1,2'b01);
    add(0,0, 0,0,0,1,2'b01);
    add(0,1, 0,0,1,1,2'b11);
    add(1,0, 1,0,0,0,2'b10);
    // Test 5: reset from pause, reset in idle, lap in run has no clear
    add(0,0, 0,0,0,0,2'b10);
    add(0,1, 0,1,0,0,2'b00);
    add(0,0, 0,0,0,0,2'b00);
    add(0,1, 0,1,0,0,2'b00);
    add(0,0, 0,0,0,0,2'b00);
    add(1,0, 0,0,0,1,2'b01);
    add(0,1, 0,0,1,1,2'b11);
    add(0,0, 0,0,1,1,2'b11);
    add(0,1, 0,0,0,1,2'b01);
    add(0,0, 1,0,0,1,2'b01);
    // Test 6: both buttons rise together in RUN -> PAUSE only
    add(1,1, 0,0,0,0,2'b10);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 6'b000000);
    rst_n = 1'b1;
    step(0, 0);
    check("idle_after_reset", 6'b000000);

    foreach (vecs[i]) begin
      step(vecs[i].ss, vecs[i].lr);
      check($sformatf("vec%0d", i),
            {vecs[i].tick, vecs[i].clr, vecs[i].hold, vecs[i].run, vecs[i].st});
    end

    // ss held 20 cycles: no toggling, stays in PAUSE
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      check($sformatf("ss_held%0d", i), 6'b000010);
    end
    step(0, 0);
    check("ss_released", 6'b000010);
    step(1, 0);
    check("resume_after_hold", 6'b000101);
    step(0, 0);
    step(0, 0);

    // Test 1: asynchronous reset mid-cycle while running
    #2;
    rst_n = 1'b0;
    btn_start_stop = 1'b1;
    #1;
    check("async_reset", 6'b000000);
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, 0);
      check($sformatf("held_through_reset%0d", i), 6'b000000);
    end
    step(0, 0);
    check("fresh_idle", 6'b000000);
    step(1, 0);
    check("fresh_press_run", 6'b000101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
